// File: rtl/aes_decipher_block.sv
// Iterative AES-128/256 inverse cipher; round keys are fetched from an external key memory addressed by round.
// Define AES_DECIPHER_PARALLEL_SBOX_EN to substitute the whole state in one cycle instead of one word per cycle.
module aes_decipher_block (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  // state | meaning
  // IDLE  | result valid, waiting for next
  // INIT  | initial AddRoundKey + InvShiftRows
  // SBOX  | InvSubBytes over the state
  // MAIN  | AddRoundKey + InvMixColumns + InvShiftRows, or final AddRoundKey
  typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

  state_t       state, state_nxt;
  logic [3:0]   round_nxt;
  logic [127:0] block_nxt;
  logic         ready_nxt;
`ifndef AES_DECIPHER_PARALLEL_SBOX_EN
  logic [1:0]   sword, sword_nxt;
`endif

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse affine map followed by the field inverse, computed as t^254 (0 maps to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] t, sq, acc;
    t   = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    sq  = t;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
    return {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_word(s[127:96]), inv_mix_word(s[95:64]),
            inv_mix_word(s[63:32]), inv_mix_word(s[31:0])};
  endfunction

  // Byte (row r, column c) sits at s[127-32c-8r -: 8]; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = s[127-32*((c-r+4)%4)-8*r -: 8];
    return o;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      round     <= 4'd0;
      new_block <= '0;
      ready     <= 1'b1;
`ifndef AES_DECIPHER_PARALLEL_SBOX_EN
      sword     <= 2'd0;
`endif
    end else begin
      state     <= state_nxt;
      round     <= round_nxt;
      new_block <= block_nxt;
      ready     <= ready_nxt;
`ifndef AES_DECIPHER_PARALLEL_SBOX_EN
      sword     <= sword_nxt;
`endif
    end
  end

  // The round counter's start value carries the key length, so keylen needs no separate register.
  always_comb begin
    state_nxt = state;
    round_nxt = round;
    block_nxt = new_block;
    ready_nxt = ready;
`ifndef AES_DECIPHER_PARALLEL_SBOX_EN
    sword_nxt = sword;
`endif
    case (state)
      IDLE: begin
        if (next) begin
          round_nxt = keylen ? 4'd14 : 4'd10;
          ready_nxt = 1'b0;
          state_nxt = INIT;
        end
      end
      INIT: begin
        block_nxt = inv_shift_rows(block ^ round_key);
        round_nxt = round - 4'd1;
`ifndef AES_DECIPHER_PARALLEL_SBOX_EN
        sword_nxt = 2'd0;
`endif
        state_nxt = SBOX;
      end
      SBOX: begin
`ifdef AES_DECIPHER_PARALLEL_SBOX_EN
        block_nxt = {inv_sub_word(new_block[127:96]), inv_sub_word(new_block[95:64]),
                     inv_sub_word(new_block[63:32]), inv_sub_word(new_block[31:0])};
        state_nxt = MAIN;
`else
        case (sword)
          2'd0:    block_nxt[127:96] = inv_sub_word(new_block[127:96]);
          2'd1:    block_nxt[95:64]  = inv_sub_word(new_block[95:64]);
          2'd2:    block_nxt[63:32]  = inv_sub_word(new_block[63:32]);
          default: block_nxt[31:0]   = inv_sub_word(new_block[31:0]);
        endcase
        sword_nxt = sword + 2'd1;
        if (sword == 2'd3) state_nxt = MAIN;
`endif
      end
      MAIN: begin
        if (round != 4'd0) begin
          block_nxt = inv_shift_rows(inv_mix_columns(new_block ^ round_key));
          round_nxt = round - 4'd1;
          state_nxt = SBOX;
        end else begin
          block_nxt = new_block ^ round_key;
          ready_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_decipher_block.sv
// Bench for aes_decipher_block: FIPS-197 vectors plus random blocks encrypted by a byte-level forward-cipher model.
// Latency expectations follow AES_DECIPHER_PARALLEL_SBOX_EN when it is defined.
module tb_aes_decipher_block;

`ifdef AES_DECIPHER_PARALLEL_SBOX_EN
  localparam int LAT128 = 22, LAT256 = 30, B0 = 3, B1 = 9, B2 = 15, ABORT_CYC = 12;
`else
  localparam int LAT128 = 52, LAT256 = 72, B0 = 5, B1 = 20, B2 = 40, ABORT_CYC = 30;
`endif
  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         next = 1'b0;
  logic         keylen = 1'b0;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] block = '0;
  logic [127:0] new_block;
  logic         ready;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox [256];
  logic [127:0] rk [16];
  int           lat;
  logic [127:0] res;
  logic [3:0]   rseq [$];

  always #5 clk = ~clk;
  always_comb round_key = rk[round];

  aes_decipher_block dut (
    .clk(clk), .reset_n(reset_n), .next(next), .keylen(keylen), .round(round),
    .round_key(round_key), .block(block), .new_block(new_block), .ready(ready)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Forward S-box from the generator-3 walk: p steps by x3, q tracks its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xt(p);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_w(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic key_expand(input logic [255:0] key, input logic kl);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = kl ? 8 : 4;
    nr = kl ? 14 : 10;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) rk[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_w(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Forward cipher on a 16-byte array, byte i = row i%4 of column i/4.
  function automatic logic [127:0] encrypt(input logic [127:0] pt_in, input logic kl);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    int nr;
    nr = kl ? 14 : 10;
    for (int i = 0; i < 16; i++) s[i] = pt_in[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[rnd][127-8*i -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Pulses next once, optionally re-pulses next/toggles keylen at cycles g0..g2 or asserts reset at abort_at.
  task automatic run_op(input logic kl, input logic [127:0] ct, input int g0, input int g1,
                        input int g2, input int abort_at);
    int e;
    rseq.delete();
    lat = -1;
    @(negedge clk);
    keylen = kl; block = ct; next = 1'b1;
    @(posedge clk);
    e = 1;
    @(negedge clk);
    next = 1'b0;
    rseq.push_back(round);
    while (e < 200) begin
      if (ready === 1'b1) begin
        lat = e;
        break;
      end
      if (e == abort_at) begin
        reset_n = 1'b0;
        break;
      end
      if (e == g0 || e == g1 || e == g2) begin
        next = 1'b1;
        keylen = ~keylen;
      end else begin
        next = 1'b0;
      end
      @(posedge clk);
      e++;
      @(negedge clk);
      rseq.push_back(round);
    end
    next = 1'b0;
    res = new_block;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #10;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (round !== 4'd0) begin errors++; $display("FAIL reset_round got %0d want 0", round); end
    checks++; if (new_block !== 128'h0) begin errors++; $display("FAIL reset_block got %h want 0", new_block); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({ready, round, new_block} !== {1'b1, 4'd0, 128'h0}) begin
        errors++;
        $display("FAIL idle_quiet cyc %0d got ready=%b round=%0d blk=%h want 1/0/0", i, ready, round, new_block);
      end
    end
  endtask

  task automatic test_c1();
    logic [3:0] comp [$];
    key_expand(KEY_C1, 1'b0);
    checks++;
    if (encrypt(PT, 1'b0) !== CT_C1) begin errors++; $display("FAIL model_c1 got %h want %h", encrypt(PT, 1'b0), CT_C1); end
    run_op(1'b0, CT_C1, 0, 0, 0, 0);
    checks++; if (lat != LAT128) begin errors++; $display("FAIL c1_latency got %0d want %0d", lat, LAT128); end
    checks++; if (res !== PT) begin errors++; $display("FAIL c1_result got %h want %h", res, PT); end
    foreach (rseq[i]) if (comp.size() == 0 || comp[$] != rseq[i]) comp.push_back(rseq[i]);
    checks++; if (comp.size() != 11) begin errors++; $display("FAIL c1_round_count got %0d want 11", comp.size()); end
    for (int i = 0; i < 11 && i < comp.size(); i++) begin
      checks++;
      if (comp[i] !== 4'(10 - i)) begin errors++; $display("FAIL c1_round_seq idx %0d got %0d want %0d", i, comp[i], 10 - i); end
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({ready, new_block} !== {1'b1, PT}) begin errors++; $display("FAIL c1_hold got ready=%b blk=%h want 1/%h", ready, new_block, PT); end
  endtask

  task automatic test_c3();
    key_expand(KEY_C3, 1'b1);
    checks++;
    if (encrypt(PT, 1'b1) !== CT_C3) begin errors++; $display("FAIL model_c3 got %h want %h", encrypt(PT, 1'b1), CT_C3); end
    run_op(1'b1, CT_C3, 0, 0, 0, 0);
    checks++; if (lat != LAT256) begin errors++; $display("FAIL c3_latency got %0d want %0d", lat, LAT256); end
    checks++; if (res !== PT) begin errors++; $display("FAIL c3_result got %h want %h", res, PT); end
  endtask

  task automatic test_busy();
    key_expand(KEY_C1, 1'b0);
    run_op(1'b0, CT_C1, B0, B1, B2, 0);
    checks++; if (lat != LAT128) begin errors++; $display("FAIL busy_latency got %0d want %0d", lat, LAT128); end
    checks++; if (res !== PT) begin errors++; $display("FAIL busy_result got %h want %h", res, PT); end
  endtask

  task automatic test_abort();
    key_expand(KEY_C1, 1'b0);
    run_op(1'b0, CT_C1, 0, 0, 0, ABORT_CYC);
    #1;
    checks++;
    if ({ready, round, new_block} !== {1'b1, 4'd0, 128'h0}) begin
      errors++;
      $display("FAIL abort_state got ready=%b round=%0d blk=%h want 1/0/0", ready, round, new_block);
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_op(1'b0, CT_C1, 0, 0, 0, 0);
    checks++; if (lat != LAT128) begin errors++; $display("FAIL abort_restart_latency got %0d want %0d", lat, LAT128); end
    checks++; if (res !== PT) begin errors++; $display("FAIL abort_restart_result got %h want %h", res, PT); end
  endtask

  task automatic test_back_to_back();
    int e;
    key_expand(KEY_C1, 1'b0);
    @(negedge clk);
    keylen = 1'b0; block = CT_C1; next = 1'b1;
    e = 0;
    do begin
      @(posedge clk); e++; @(negedge clk);
    end while (ready !== 1'b1 && e < 200);
    checks++; if (e != LAT128) begin errors++; $display("FAIL b2b_first_latency got %0d want %0d", e, LAT128); end
    checks++; if (new_block !== PT) begin errors++; $display("FAIL b2b_first_result got %h want %h", new_block, PT); end
    key_expand(KEY_C3, 1'b1);
    keylen = 1'b1; block = CT_C3;
    @(posedge clk); e = 1; @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_one_cycle got %b want 0", ready); end
    while (ready !== 1'b1 && e < 200) begin
      @(posedge clk); e++; @(negedge clk);
    end
    checks++; if (e != LAT256) begin errors++; $display("FAIL b2b_second_latency got %0d want %0d", e, LAT256); end
    checks++; if (new_block !== PT) begin errors++; $display("FAIL b2b_second_result got %h want %h", new_block, PT); end
    next = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_after got %b want 1", ready); end
  endtask

  task automatic test_random();
    logic [255:0] key;
    logic [127:0] pt_r, ct;
    logic         kl;
    for (int n = 0; n < 6; n++) begin
      key  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt_r = {$urandom, $urandom, $urandom, $urandom};
      kl   = 1'($urandom_range(0, 1));
      key_expand(key, kl);
      ct = encrypt(pt_r, kl);
      run_op(kl, ct, 0, 0, 0, 0);
      checks++;
      if (lat != (kl ? LAT256 : LAT128)) begin
        errors++; $display("FAIL rand_latency iter %0d got %0d want %0d", n, lat, kl ? LAT256 : LAT128);
      end
      checks++;
      if (res !== pt_r) begin errors++; $display("FAIL rand_result iter %0d got %h want %h", n, res, pt_r); end
    end
  endtask

  initial begin
    build_sbox();
    for (int i = 0; i < 16; i++) rk[i] = '0;
    test_reset();
    test_c1();
    test_c3();
    test_busy();
    test_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_decipher_block.md
Name: aes_decipher_block

Overview:
- Iterative AES inverse cipher datapath, FIPS-197 InvCipher, for 128- and 256-bit keys.
- Processes one 128-bit block per `next` pulse and fetches round keys from the key memory by driving `round`.
- Contains its own inverse S-box, so it does not share the encipher S-box.
- Sits beside the encipher block under the AES core and shares its key memory.

Parameters:
- None. Round counts are fixed local constants: AES-128 = 10, AES-256 = 14.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- next  in  1  start pulse; sampled only in IDLE.
- keylen  in  1  0 = AES-128, 1 = AES-256; latched when a start is accepted.
- round  out  4  current round index, addresses the key memory.
- round_key  in  128  round key for index `round`, combinational, valid in the same cycle.
- block  in  128  ciphertext; must be stable during the INIT cycle.
- new_block  out  128  plaintext/state register; final value is valid while ready = 1.
- ready  out  1  1 = idle with the result valid.

Behaviour:
- Reset values: new_block = 0, round = 0, ready = 1, FSM = IDLE, sword counter = 0, latched keylen = 0. Reset is asynchronous.
- Reset mid-operation aborts immediately. Nothing resumes afterwards; the next `next` starts a fresh operation.
- State is four 32-bit word registers w0..w3. w0 is block[127:96].
- Sub-functions:
  - InvShiftRows rotates row r right by r.
  - InvMixColumns multiplies each column by the matrix rows {0e,0b,0d,09}, GF(2^8) polynomial 0x11b.
  - AddRoundKey is XOR with round_key.
- FSM states: IDLE, INIT, SBOX, MAIN.
- IDLE:
  - If next = 1: latch keylen; round <= 10 or 14; ready <= 0; go to INIT.
  - Otherwise hold all state.
- INIT:
  - state <= InvShiftRows(block ^ round_key).
  - round <= round - 1; sword <= 0; go to SBOX.
- SBOX:
  - Each cycle, word[sword] <= InvSubWord(word[sword]), four byte lookups in one cycle; sword <= sword + 1.
  - After sword = 3 (wraps to 0), go to MAIN. Takes exactly 4 cycles.
- MAIN, with round > 0:
  - state <= InvShiftRows(InvMixColumns(state ^ round_key)).
  - round <= round - 1; go to SBOX.
- MAIN, with round = 0:
  - state <= state ^ round_key; ready <= 1; go to IDLE.
  - round stays 0.
- Latency from the cycle `next` is sampled to ready = 1:
  - AES-128: 1 + 1 + 10×5 = 52 edges.
  - AES-256: 1 + 1 + 14×5 = 72 edges.
- `next` while busy is ignored and has no effect on the operation.
- `next` held high keeps restarting each time IDLE is reached. The result is valid for at least the one cycle ready = 1 before INIT begins.
- keylen changes mid-operation have no effect because it is latched at start.
- The round counter never underflows. MAIN with round = 0 always exits to IDLE.
- `round` sequence:
  - AES-128: 10 during INIT, then 9..1 for the main rounds, 0 for the final round.
  - AES-256: 14, then 13..1, then 0.
- new_block changes only in INIT, SBOX and MAIN. It holds its value in IDLE.

Optional Feature:
- Macro: AES_DECIPHER_PARALLEL_SBOX_EN.
- Defined:
  - Instantiate 16 inverse S-boxes; SBOX substitutes all four words in 1 cycle.
  - The sword counter is removed.
  - Latency: AES-128 = 22, AES-256 = 30 edges.
- Undefined:
  - One 32-bit inverse S-box word per cycle, as described above.
- All other behaviour and all ports are identical in both builds.

Test Plan:
- Reset check: assert reset_n = 0, then release → ready = 1, new_block = 0, round = 0; no activity with next = 0 for 20 cycles.
- FIPS-197 C.1, AES-128: key 000102…0f (bench key-memory model indexed by round), block 69c4e0d86a7b0430d8cdb78070b4c55a, pulse next → ready rises exactly 52 edges later (22 with the macro), new_block = 00112233445566778899aabbccddeeff; round sequence 10, 9..0 checked.
- FIPS-197 C.3, AES-256: key 000102…1f, block 8ea2b7ca516745bfeafc49904b496089 → new_block = 00112233445566778899aabbccddeeff after 72 edges (30 with the macro).
- Busy robustness: pulse next and toggle keylen at cycles 5, 20 and 40 of a C.1 run → result and latency unchanged.
- Reset mid-operation: reset_n low at cycle 30 of a C.1 run, then restart → first result correct; no residue from the aborted run.
- Back-to-back: next held high across two C.1/C.3 runs with alternating keylen → both results correct, ready = 1 for exactly one cycle between runs.
